// File: rtl/simd_dispatch_issuer.sv
// Command issuer between the command FIFO and PROC_COUNT SIMD cores: screens each
// popped command against in-flight core destinations and issues it as four acked beats.
module simd_dispatch_issuer #(
    parameter  int PROC_COUNT = 4,
    parameter  int ADDR_W     = 16,
    parameter  int OP_W       = 4,
    localparam int CMD_W      = OP_W + 3 * ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [CMD_W-1:0]      i_cmd,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_pop,
    output logic [CMD_W-1:0]      o_wb_cmd,
    output logic                  o_wb_valid,
    input  logic                  i_wb_ready,
    input  logic [PROC_COUNT-1:0] i_busy,
    input  logic [PROC_COUNT-1:0] i_finish,
    input  logic                  i_ack,
    output logic [PROC_COUNT-1:0] o_en_arr,
    output logic                  o_beat_valid,
    output logic [1:0]            o_beat_type,
    output logic [ADDR_W-1:0]     o_beat_data,
    output logic                  o_idle
);

    localparam int PTR_W = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET       = 3'd1,
        ST_CHECK     = 3'd2,
        ST_SELECT    = 3'd3,
        ST_BEAT      = 3'd4,
        ST_WRITEBACK = 3'd5
    } state_t;

    state_t                  state_r;
    logic [CMD_W-1:0]        cmd_r;
    logic [PTR_W-1:0]        rr_ptr_r;
    logic [PTR_W-1:0]        sel_r;
    logic [1:0]              beat_idx_r;
    logic [PROC_COUNT-1:0]   sb_valid_r;
    logic [ADDR_W-1:0]       sb_dst_r [PROC_COUNT];

    logic [ADDR_W-1:0]       cmd_src1_s;
    logic [ADDR_W-1:0]       cmd_src2_s;
    logic [ADDR_W-1:0]       cmd_dst_s;
    logic [PROC_COUNT-1:0]   hit_s;
    logic                    hazard_s;
    logic [PROC_COUNT-1:0]   free_s;
    logic                    found_s;
    logic [PTR_W-1:0]        pick_s;
    logic [PROC_COUNT-1:0]   pick_onehot_s;
    logic [PROC_COUNT-1:0]   sel_onehot_s;
    logic                    write_ack_s;
    logic [PROC_COUNT-1:0]   sb_valid_nxt_s;
    logic                    stay_idle_s;
    logic                    idle_nxt_s;
    logic [PTR_W-1:0]        rr_next_s;

    // Payload carried by each beat kind; the opcode is zero-extended onto the address bus.
    function automatic logic [ADDR_W-1:0] beat_payload(input logic [1:0] kind,
                                                       input logic [CMD_W-1:0] cmd);
        logic [ADDR_W-1:0] data;
        case (kind)
            2'd0:    data = cmd[ADDR_W-1:0];
            2'd1:    data = cmd[2*ADDR_W-1:ADDR_W];
            2'd2:    data = ADDR_W'(cmd[CMD_W-1:3*ADDR_W]);
            2'd3:    data = cmd[3*ADDR_W-1:2*ADDR_W];
            default: data = '0;
        endcase
        return data;
    endfunction

    assign cmd_src1_s = cmd_r[ADDR_W-1:0];
    assign cmd_src2_s = cmd_r[2*ADDR_W-1:ADDR_W];
    assign cmd_dst_s  = cmd_r[3*ADDR_W-1:2*ADDR_W];

    // RAW/WAW hazard: any live destination matching a source or the destination.
    always_comb begin
        for (int k = 0; k < PROC_COUNT; k++) begin
            hit_s[k] = sb_valid_r[k] & ((sb_dst_r[k] == cmd_src1_s) |
                                        (sb_dst_r[k] == cmd_src2_s) |
                                        (sb_dst_r[k] == cmd_dst_s));
        end
        hazard_s = |hit_s;
    end

    // Round-robin scan from rr_ptr for a core that is neither busy nor holding a result.
    always_comb begin
        logic [PTR_W-1:0] cand;
        free_s  = ~i_busy & ~sb_valid_r;
        found_s = 1'b0;
        pick_s  = '0;
        cand    = '0;
        for (int i = 0; i < PROC_COUNT; i++) begin
            cand = PTR_W'((int'(rr_ptr_r) + i) % PROC_COUNT);
            if (!found_s && free_s[cand]) begin
                found_s = 1'b1;
                pick_s  = cand;
            end else begin
                found_s = found_s;
                pick_s  = pick_s;
            end
        end
        pick_onehot_s = {{(PROC_COUNT-1){1'b0}}, 1'b1} << pick_s;
    end

    // Scoreboard next value: finish pulses retire, a WRITE ack for the same core wins.
    always_comb begin
        write_ack_s    = (state_r == ST_BEAT) && i_ack && (beat_idx_r == 2'd3);
        sel_onehot_s   = {{(PROC_COUNT-1){1'b0}}, 1'b1} << sel_r;
        sb_valid_nxt_s = (sb_valid_r & ~i_finish) | (write_ack_s ? sel_onehot_s : {PROC_COUNT{1'b0}});
        rr_next_s      = (sel_r == PTR_W'(PROC_COUNT - 1)) ? {PTR_W{1'b0}} : sel_r + PTR_W'(1);
    end

    // Predicts whether the next cycle is IDLE with an empty scoreboard, so o_idle can be registered.
    always_comb begin
        case (state_r)
            ST_IDLE:      stay_idle_s = !i_cmd_valid;
            ST_WRITEBACK: stay_idle_s = i_wb_ready;
            ST_BEAT:      stay_idle_s = write_ack_s;
            default:      stay_idle_s = 1'b0;
        endcase
        idle_nxt_s = stay_idle_s && (sb_valid_nxt_s == {PROC_COUNT{1'b0}});
    end

    // Scoreboard storage of in-flight destinations.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sb_valid_r <= '0;
            for (int k = 0; k < PROC_COUNT; k++) begin
                sb_dst_r[k] <= '0;
            end
        end else begin
            sb_valid_r <= sb_valid_nxt_s;
            if (write_ack_s) begin
                sb_dst_r[sel_r] <= cmd_dst_s;
            end
        end
    end

    // Issue FSM with registered strobes, beat bus and writeback request.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r      <= ST_IDLE;
            cmd_r        <= '0;
            rr_ptr_r     <= '0;
            sel_r        <= '0;
            beat_idx_r   <= 2'd0;
            o_cmd_pop    <= 1'b0;
            o_wb_valid   <= 1'b0;
            o_wb_cmd     <= '0;
            o_beat_valid <= 1'b0;
            o_en_arr     <= '0;
            o_beat_type  <= 2'd0;
            o_beat_data  <= '0;
            o_idle       <= 1'b1;
        end else begin
            o_idle    <= idle_nxt_s;
            o_cmd_pop <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        cmd_r     <= i_cmd;
                        o_cmd_pop <= 1'b1;
                        state_r   <= ST_GET;
                    end
                end
                ST_GET: begin
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (hazard_s) begin
                        o_wb_valid <= 1'b1;
                        o_wb_cmd   <= cmd_r;
                        state_r    <= ST_WRITEBACK;
                    end else begin
                        state_r <= ST_SELECT;
                    end
                end
                ST_WRITEBACK: begin
                    if (i_wb_ready) begin
                        o_wb_valid <= 1'b0;
                        o_wb_cmd   <= '0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (found_s) begin
                        sel_r        <= pick_s;
                        beat_idx_r   <= 2'd0;
                        o_beat_valid <= 1'b1;
                        o_en_arr     <= pick_onehot_s;
                        o_beat_type  <= 2'd0;
                        o_beat_data  <= beat_payload(2'd0, cmd_r);
                        state_r      <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    // Payload only moves on an ack; the final ack retires into the scoreboard.
                    if (i_ack) begin
                        if (beat_idx_r == 2'd3) begin
                            rr_ptr_r     <= rr_next_s;
                            o_beat_valid <= 1'b0;
                            o_en_arr     <= '0;
                            o_beat_type  <= 2'd0;
                            o_beat_data  <= '0;
                            state_r      <= ST_IDLE;
                        end else begin
                            beat_idx_r  <= beat_idx_r + 2'd1;
                            o_beat_type <= beat_idx_r + 2'd1;
                            o_beat_data <= beat_payload(beat_idx_r + 2'd1, cmd_r);
                        end
                    end
                end
                default: begin
                    o_wb_valid   <= 1'b0;
                    o_beat_valid <= 1'b0;
                    o_en_arr     <= '0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_dispatch_issuer.sv
// Self-checking bench for simd_dispatch_issuer: beat and writeback expectations are
// queued when commands are driven and compared as the issuer produces them.
module tb_simd_dispatch_issuer;

    localparam int P  = 4;
    localparam int AW = 16;
    localparam int OW = 4;
    localparam int CW = OW + 3 * AW;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic [CW-1:0] i_cmd;
    logic          i_cmd_valid;
    logic          o_cmd_pop;
    logic [CW-1:0] o_wb_cmd;
    logic          o_wb_valid;
    logic          i_wb_ready;
    logic [P-1:0]  i_busy;
    logic [P-1:0]  i_finish;
    logic          i_ack;
    logic [P-1:0]  o_en_arr;
    logic          o_beat_valid;
    logic [1:0]    o_beat_type;
    logic [AW-1:0] o_beat_data;
    logic          o_idle;

    typedef struct {
        logic [1:0]    t;
        logic [AW-1:0] d;
        logic [P-1:0]  en;
    } beat_t;

    beat_t         exp_q[$];
    logic [CW-1:0] wb_q[$];
    int            checks   = 0;
    int            failures = 0;

    simd_dispatch_issuer #(.PROC_COUNT(P), .ADDR_W(AW), .OP_W(OW)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_cmd        (i_cmd),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_pop    (o_cmd_pop),
        .o_wb_cmd     (o_wb_cmd),
        .o_wb_valid   (o_wb_valid),
        .i_wb_ready   (i_wb_ready),
        .i_busy       (i_busy),
        .i_finish     (i_finish),
        .i_ack        (i_ack),
        .o_en_arr     (o_en_arr),
        .o_beat_valid (o_beat_valid),
        .o_beat_type  (o_beat_type),
        .o_beat_data  (o_beat_data),
        .o_idle       (o_idle)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_cmd(input logic [OW-1:0] op, input logic [AW-1:0] dst,
                              input logic [AW-1:0] src2, input logic [AW-1:0] src1, input int core);
        beat_t b;
        b.en = 4'b0001 << core;
        b.t = 2'd0; b.d = src1;     exp_q.push_back(b);
        b.t = 2'd1; b.d = src2;     exp_q.push_back(b);
        b.t = 2'd2; b.d = AW'(op);  exp_q.push_back(b);
        b.t = 2'd3; b.d = dst;      exp_q.push_back(b);
    endtask

    task automatic push_cmd(input logic [OW-1:0] op, input logic [AW-1:0] dst,
                            input logic [AW-1:0] src2, input logic [AW-1:0] src1);
        int n = 0;
        i_cmd       = {op, dst, src2, src1};
        i_cmd_valid = 1'b1;
        tick();
        while (o_cmd_pop !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (o_cmd_pop !== 1'b1) begin
            failures++;
            $display("FAIL cmd_pop: got %b, wanted 1 within 20 cycles", o_cmd_pop);
        end
        i_cmd_valid = 1'b0;
    endtask

    // Consumes queued beats; optionally withholds ack from one beat type for stall_len cycles.
    task automatic drain_beats(input int stall_type, input int stall_len, input int budget);
        int    waited  = 0;
        int    stalled = 0;
        bit    started = 1'b0;
        beat_t b;
        while (exp_q.size() > 0 && waited < budget) begin
            if (o_beat_valid === 1'b1) begin
                started = 1'b1;
                checks++;
                if (o_beat_type !== exp_q[0].t || o_beat_data !== exp_q[0].d || o_en_arr !== exp_q[0].en) begin
                    failures++;
                    $display("FAIL beat: got type=%0d data=%h en=%b, wanted type=%0d data=%h en=%b",
                             o_beat_type, o_beat_data, o_en_arr, exp_q[0].t, exp_q[0].d, exp_q[0].en);
                end
                if (int'(exp_q[0].t) == stall_type && stalled < stall_len) begin
                    i_ack = 1'b0;
                    stalled++;
                end else begin
                    i_ack = 1'b1;
                    b = exp_q.pop_front();
                end
            end else if (started) begin
                checks++;
                failures++;
                $display("FAIL beat_gap: got o_beat_valid=0, wanted 1 with %0d beats pending", exp_q.size());
            end
            tick();
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got %0d beats outstanding, wanted 0", exp_q.size());
            exp_q.delete();
        end
        i_ack = 1'b1;
        checks++;
        if (o_beat_valid !== 1'b0 || o_en_arr !== 4'b0000) begin
            failures++;
            $display("FAIL beat_end: got valid=%b en=%b, wanted valid=0 en=0000", o_beat_valid, o_en_arr);
        end
    endtask

    task automatic dispatch(input logic [OW-1:0] op, input logic [AW-1:0] dst,
                            input logic [AW-1:0] src2, input logic [AW-1:0] src1, input int core);
        expect_cmd(op, dst, src2, src1, core);
        push_cmd(op, dst, src2, src1);
        drain_beats(-1, 0, 20);
    endtask

    task automatic pulse_finish(input logic [P-1:0] mask);
        i_finish = mask;
        tick();
        i_finish = 4'b0000;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_cmd = '0; i_cmd_valid = 1'b0; i_wb_ready = 1'b0;
        i_busy = 4'b0000; i_finish = 4'b0000; i_ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({o_cmd_pop, o_wb_valid, o_beat_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes: got pop/wb/beat=%b, wanted 000", {o_cmd_pop, o_wb_valid, o_beat_valid});
        end
        checks++;
        if (o_en_arr !== 4'b0000 || o_beat_type !== 2'd0 || o_beat_data !== 16'h0000 || o_wb_cmd !== 52'h0) begin
            failures++;
            $display("FAIL reset_data: got en=%b type=%0d data=%h wb=%h, wanted all zero",
                     o_en_arr, o_beat_type, o_beat_data, o_wb_cmd);
        end
        checks++;
        if (o_idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got %b, wanted 1", o_idle);
        end
        i_rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        i_ack = 1'b1;
        expect_cmd(4'd3, 16'h0040, 16'h0020, 16'h0010, 0);
        push_cmd(4'd3, 16'h0040, 16'h0020, 16'h0010);
        tick();
        checks++;
        if (o_cmd_pop !== 1'b0 || o_beat_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pop_pulse: got pop=%b beat=%b, wanted 0 0", o_cmd_pop, o_beat_valid);
        end
        tick();
        checks++;
        if (o_beat_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early_beat: got %b, wanted 0", o_beat_valid);
        end
        tick();
        checks++;
        if (o_beat_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: got beat_valid=%b 3 cycles after pop, wanted 1", o_beat_valid);
        end
        drain_beats(-1, 0, 10);
        checks++;
        if (o_idle !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_sb: got o_idle=%b, wanted 0", o_idle);
        end
    endtask

    task automatic test_raw_hazard();
        int n = 0;
        i_wb_ready = 1'b0;
        wb_q.push_back({4'd1, 16'h0050, 16'h0060, 16'h0040});
        push_cmd(4'd1, 16'h0050, 16'h0060, 16'h0040);
        while (o_wb_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_wb_valid !== 1'b1 || o_wb_cmd !== wb_q[0] || o_beat_valid !== 1'b0) begin
                failures++;
                $display("FAIL raw_hold: cycle %0d got wb_valid=%b cmd=%h beat=%b, wanted 1 %h 0",
                         i, o_wb_valid, o_wb_cmd, o_beat_valid, wb_q[0]);
            end
            if (i == 3) i_wb_ready = 1'b1;
            tick();
        end
        void'(wb_q.pop_front());
        checks++;
        if (o_wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL raw_release: got wb_valid=%b, wanted 0", o_wb_valid);
        end
        i_wb_ready = 1'b0;
    endtask

    task automatic test_hazard_clear();
        wb_q.push_back({4'd2, 16'h0070, 16'h0071, 16'h0040});
        push_cmd(4'd2, 16'h0070, 16'h0071, 16'h0040);
        tick();
        i_finish = 4'b0001;
        tick();
        i_finish = 4'b0000;
        checks++;
        if (o_wb_valid !== 1'b1 || o_wb_cmd !== wb_q[0]) begin
            failures++;
            $display("FAIL clear_precheck: got wb_valid=%b cmd=%h, wanted 1 %h", o_wb_valid, o_wb_cmd, wb_q[0]);
        end
        void'(wb_q.pop_front());
        i_wb_ready = 1'b1;
        tick();
        i_wb_ready = 1'b0;
        checks++;
        if (o_wb_valid !== 1'b0 || o_idle !== 1'b1) begin
            failures++;
            $display("FAIL clear_idle: got wb_valid=%b idle=%b, wanted 0 1", o_wb_valid, o_idle);
        end
        dispatch(4'd2, 16'h0070, 16'h0071, 16'h0040, 1);
    endtask

    task automatic test_round_robin();
        pulse_finish(4'b0010);
        dispatch(4'd4, 16'h0100, 16'h0101, 16'h0102, 2);
        dispatch(4'd4, 16'h0200, 16'h0201, 16'h0202, 3);
        pulse_finish(4'b1000);
        dispatch(4'd4, 16'h0300, 16'h0301, 16'h0302, 0);
        pulse_finish(4'b0001);
        i_busy = 4'b0010;
        dispatch(4'd7, 16'h0400, 16'h0401, 16'h0402, 3);
        i_busy = 4'b0000;
    endtask

    task automatic test_all_busy();
        bit seen = 1'b0;
        pulse_finish(4'b1100);
        checks++;
        if (o_idle !== 1'b1) begin
            failures++;
            $display("FAIL busy_sb_empty: got o_idle=%b, wanted 1", o_idle);
        end
        i_busy = 4'b1111;
        expect_cmd(4'd8, 16'h0700, 16'h0701, 16'h0702, 1);
        push_cmd(4'd8, 16'h0700, 16'h0701, 16'h0702);
        for (int i = 0; i < 8; i++) begin
            if (o_beat_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL busy_hold: got a beat while all cores busy, wanted none");
        end
        i_busy = 4'b1101;
        drain_beats(-1, 0, 10);
        i_busy = 4'b0000;
    endtask

    task automatic test_ack_stall();
        expect_cmd(4'd5, 16'h0500, 16'h0501, 16'h0502, 2);
        push_cmd(4'd5, 16'h0500, 16'h0501, 16'h0502);
        drain_beats(2, 5, 30);
    endtask

    task automatic test_reset_mid_beat();
        int n = 0;
        i_ack = 1'b1;
        push_cmd(4'd6, 16'h0600, 16'h0601, 16'h0602);
        while (o_beat_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tick();
        i_ack = 1'b0;
        checks++;
        if (o_beat_valid !== 1'b1 || o_beat_type !== 2'd1 || o_beat_data !== 16'h0601 || o_en_arr !== 4'b1000) begin
            failures++;
            $display("FAIL midbeat_ld2: got valid=%b type=%0d data=%h en=%b, wanted 1 1 0601 1000",
                     o_beat_valid, o_beat_type, o_beat_data, o_en_arr);
        end
        tick();
        i_rstn = 1'b0;
        tick();
        checks++;
        if (o_beat_valid !== 1'b0 || o_en_arr !== 4'b0000 || o_idle !== 1'b1) begin
            failures++;
            $display("FAIL midbeat_reset: got valid=%b en=%b idle=%b, wanted 0 0000 1",
                     o_beat_valid, o_en_arr, o_idle);
        end
        i_rstn = 1'b1;
        i_ack  = 1'b1;
        tick();
        dispatch(4'd9, 16'h0800, 16'h0801, 16'h0802, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_raw_hazard();
        test_hazard_clear();
        test_round_robin();
        test_all_busy();
        test_ack_stall();
        test_reset_mid_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
